alu_req_scheduler: RTL and testbench
====================================

// Module: alu_req_scheduler
// PURPOSE
//   Shares one 16-bit combinational ALU between NREQ requesters.
//   - Round-robin arbitration; valid/ready handshakes on request and response.
//   - Registers the granted operands, drives the ALU, waits ALU_LAT cycles, captures result and flags.
//   - Returns the captured response to the granted requester only.
//   - Sits between the core's issue ports and the ALU instance; one operation in flight at a time.
// PARAMETERS
//   NREQ     2    number of requesters (2..8)
//   ALU_LAT  1    ALU settle time in cycles before sampling (1..15)
//   W        16   operand/result width
// PORTS
//   clk          in   1        system clock, rising edge
//   rst_n        in   1        asynchronous, active-low reset
//   req_valid    in   NREQ     per-requester operation valid
//   req_ready    out  NREQ     per-requester accept (one-hot or zero)
//   req_op       in   3*NREQ   per-requester ALU control code, slice i = [3i+2:3i]
//   req_x        in   W*NREQ   per-requester operand X
//   req_y        in   W*NREQ   per-requester operand Y
//   req_cin      in   NREQ     per-requester carry-in
//   rsp_valid    out  NREQ     per-requester response valid (one-hot or zero)
//   rsp_ready    in   NREQ     per-requester response accept
//   rsp_z        out  W        result
//   rsp_flags    out  5        {c_out, lt, eq, gt, overflow}
//   rsp_err      out  1        1 = unsupported op code
//   busy         out  1        1 when state != IDLE
//   alu_c        out  3        ALU control
//   alu_x/alu_y  out  W        ALU operands
//   alu_cin      out  1        ALU carry-in
//   alu_z        in   W        ALU result
//   alu_cout, alu_lt, alu_eq, alu_gt, alu_ovf   in  1 each   ALU flags
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - state=IDLE, rr pointer=NREQ-1 so index 0 has first priority.
//   - All outputs 0, including alu_* operand registers.
//   - Reset mid-operation discards the transaction; no response is issued.
//   FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE:
//   - Grant g = first i with req_valid[i], searching from ptr+1 upward with wrap.
//   - req_ready[g]=1 combinationally; all other ready bits 0; no grant if no valid.
//   - On handshake: latch op/x/y/cin of g into alu_* registers, latch g, set ptr=g.
//   - Op 0-5 or 7: go to EXEC, cnt=ALU_LAT-1.
//   - Op 6: go straight to RESP with z=0, flags=0, err=1; the ALU result is not sampled.
//   EXEC:
//   - alu_* held stable; cnt decrements each cycle.
//   - At the edge where cnt==0: capture the result and flags below, err=0, go to RESP.
//   Capture rules:
//   - z = alu_z, except op 7 with alu_eq=1 forces z=0.
//   - c_out = alu_cout when op==2, else 0.
//   - overflow = alu_ovf when op in {2,4,5}, else 0.
//   - lt/eq/gt = ALU flags (unsigned compare), captured for all ops.
//   RESP:
//   - rsp_valid[g]=1; rsp_z, rsp_flags and rsp_err held stable until rsp_ready[g]=1.
//   - rsp_ready of other indices is ignored.
//   - On handshake go to IDLE; rsp_valid drops the next cycle.
//   Latency and throughput:
//   - Accept edge T -> rsp_valid high from edge T+ALU_LAT.
//   - Next accept no earlier than the cycle after the response handshake.
//   - Minimum period: ALU_LAT+2 cycles per operation.
//   Boundary conditions:
//   - Requester i re-requesting while its own response is pending: held off, req_ready=0 outside IDLE.
//   - All NREQ valid continuously: strict rotation, each granted once per NREQ operations.
//   - ptr wraps from NREQ-1 to 0.
//   - req_* changing after the accept edge has no effect; operands are registered.
// STRUCTURE
//   - Shared package alu_ctrl_pkg:
//     - ALU op constants OP_AND=0, OP_OR=1, OP_ADDU=2, OP_SUBU=3, OP_ADDS=4, OP_SUBS=5, OP_SLT=7.
//     - FLAG_* bit indices into rsp_flags.
//     - Scheduler state encoding.
//   - Sub-module rr_arbiter (NREQ): req vector + ptr -> one-hot grant + encoded index; purely combinational.
//   - ALU instantiated outside this block.
// TESTING
//   1. Reset, req0 op2 x=16'hFFFF y=16'h0001 -> rsp_valid[0] 1 cycle after accept (ALU_LAT=1); z=0, c_out=1, ovf=1.
//   2. req0 and req1 valid from the same cycle, ops 0/1 -> grants 0,1,0,1 over four ops; rsp_valid never to a non-granted index.
//   3. req1 op6 -> rsp_err=1, z=0, flags=0; accept-to-rsp_valid latency 1 edge regardless of ALU_LAT.
//   4. op7 x=y=16'h0005 -> z=0, eq=1; op7 x=3 y=9 -> z=1, lt=1.
//   5. Response back-pressure: rsp_ready low 5 cycles -> rsp_z/flags stable, req_ready all 0, busy=1 throughout.
//   6. rst_n low while in EXEC -> all outputs 0 immediately, no rsp_valid after release; new request served normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: op codes, response flag layout and the
// scheduler state encoding used by alu_req_scheduler.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_ADDU = 3'd2;
    localparam logic [2:0] OP_SUBU = 3'd3;
    localparam logic [2:0] OP_ADDS = 3'd4;
    localparam logic [2:0] OP_SUBS = 3'd5;
    localparam logic [2:0] OP_RSVD = 3'd6;
    localparam logic [2:0] OP_SLT  = 3'd7;

    // Bit positions inside rsp_flags = {c_out, lt, eq, gt, overflow}.
    localparam int FLAG_OVF  = 0;
    localparam int FLAG_GT   = 1;
    localparam int FLAG_EQ   = 2;
    localparam int FLAG_LT   = 3;
    localparam int FLAG_COUT = 4;
    localparam int FLAG_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_t;

    // Op 6 has no ALU meaning; it is answered with an error response.
    function automatic logic op_is_supported(input logic [2:0] op);
        return op != OP_RSVD;
    endfunction

    // Ops whose overflow flag is meaningful to the requester.
    function automatic logic op_has_ovf(input logic [2:0] op);
        return (op == OP_ADDU) || (op == OP_ADDS) || (op == OP_SUBS);
    endfunction

endpackage

// File: rtl/alu_req_scheduler_if.sv
// Requester-side bundle of the ALU scheduler: per-requester request and
// response handshakes plus the shared response payload.
interface alu_req_scheduler_if
    import alu_ctrl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_x;
    logic [W*NREQ-1:0] req_y;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_z;
    logic [FLAG_W-1:0] rsp_flags;
    logic              rsp_err;

    // Requester side (issue ports of the core).
    modport master (
        output req_valid, req_op, req_x, req_y, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_z, rsp_flags, rsp_err
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_op, req_x, req_y, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_z, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after ptr+1 (wrapping), returning it one-hot and as an index.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);
    localparam int IDXW = $clog2(NREQ);

    int cand;

    // Scan the NREQ positions after the last winner and keep the first hit.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one external combinational ALU between NREQ requesters: arbitrates
// round-robin, registers the winner's operands onto the ALU, samples the
// result after ALU_LAT cycles and returns it to that requester only.
module alu_req_scheduler
    import alu_ctrl_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ALU_LAT = 1,
    parameter int W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_req_scheduler_if.slave bus,
    output logic             busy,
    output logic [2:0]       alu_c,
    output logic [W-1:0]     alu_x,
    output logic [W-1:0]     alu_y,
    output logic             alu_cin,
    input  logic [W-1:0]     alu_z,
    input  logic             alu_cout,
    input  logic             alu_lt,
    input  logic             alu_eq,
    input  logic             alu_gt,
    input  logic             alu_ovf
);
    localparam int         IDXW     = $clog2(NREQ);
    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    sched_state_t      state, state_next;
    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   gnt_idx;
    logic [IDXW-1:0]   arb_idx;
    logic [NREQ-1:0]   arb_grant;
    logic              arb_any;
    logic [3:0]        cnt;
    logic              req_fire;
    logic              rsp_fire;

    logic [2:0]        sel_op;
    logic [W-1:0]      sel_x;
    logic [W-1:0]      sel_y;
    logic              sel_cin;

    logic [W-1:0]      z_q;
    logic [FLAG_W-1:0] flags_q;
    logic              err_q;
    logic [W-1:0]      z_cap;
    logic [FLAG_W-1:0] flags_cap;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Operand slices of the requester the arbiter is currently offering.
    assign sel_op  = bus.req_op[3*arb_idx +: 3];
    assign sel_x   = bus.req_x[W*arb_idx +: W];
    assign sel_y   = bus.req_y[W*arb_idx +: W];
    assign sel_cin = bus.req_cin[arb_idx];

    assign busy          = (state != ST_IDLE);
    assign bus.rsp_z     = z_q;
    assign bus.rsp_flags = flags_q;
    assign bus.rsp_err   = err_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates together at the edge.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next state, handshake readies and the one-hot response valid.
    always_comb begin
        state_next    = state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        req_fire      = 1'b0;
        rsp_fire      = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = arb_grant;
                req_fire      = arb_any;
                if (arb_any)
                    state_next = op_is_supported(sel_op) ? ST_EXEC : ST_RESP;
            end
            ST_EXEC: begin
                if (cnt == 4'd0) state_next = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid[gnt_idx] = 1'b1;
                rsp_fire               = bus.rsp_ready[gnt_idx];
                if (rsp_fire) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Result and flags as they will be captured from the ALU this cycle.
    always_comb begin
        z_cap     = (alu_c == OP_SLT && alu_eq) ? '0 : alu_z;
        flags_cap = '0;
        flags_cap[FLAG_COUT] = (alu_c == OP_ADDU) && alu_cout;
        flags_cap[FLAG_LT]   = alu_lt;
        flags_cap[FLAG_EQ]   = alu_eq;
        flags_cap[FLAG_GT]   = alu_gt;
        flags_cap[FLAG_OVF]  = op_has_ovf(alu_c) && alu_ovf;
    end

    // Operand registers, grant bookkeeping, settle counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset as well because they drive outputs that must read 0 out of reset.
        if (!rst_n) begin
            alu_c   <= '0;
            alu_x   <= '0;
            alu_y   <= '0;
            alu_cin <= 1'b0;
            gnt_idx <= '0;
            ptr     <= IDXW'(NREQ - 1);
            cnt     <= '0;
            z_q     <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else if (req_fire) begin
            alu_c   <= sel_op;
            alu_x   <= sel_x;
            alu_y   <= sel_y;
            alu_cin <= sel_cin;
            gnt_idx <= arb_idx;
            ptr     <= arb_idx;
            cnt     <= CNT_INIT;
            if (!op_is_supported(sel_op)) begin
                z_q     <= '0;
                flags_q <= '0;
                err_q   <= 1'b1;
            end
        end else if (state == ST_EXEC) begin
            if (cnt == 4'd0) begin
                z_q     <= z_cap;
                flags_q <= flags_cap;
                err_q   <= 1'b0;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Self-checking bench for alu_req_scheduler: a behavioural ALU drives the
// alu_* inputs, and a transaction-level timeline model predicts grants,
// response timing and response contents from the arbitration and capture rules.
module tb_alu_req_scheduler;
    import alu_ctrl_pkg::*;

    localparam int NREQ    = 3;
    localparam int ALU_LAT = 3;
    localparam int W       = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         busy;
    logic [2:0]   alu_c;
    logic [W-1:0] alu_x, alu_y, alu_z;
    logic         alu_cin, alu_cout, alu_lt, alu_eq, alu_gt, alu_ovf;

    alu_req_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

    alu_req_scheduler #(.NREQ(NREQ), .ALU_LAT(ALU_LAT), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .alu_c    (alu_c),
        .alu_x    (alu_x),
        .alu_y    (alu_y),
        .alu_cin  (alu_cin),
        .alu_z    (alu_z),
        .alu_cout (alu_cout),
        .alu_lt   (alu_lt),
        .alu_eq   (alu_eq),
        .alu_gt   (alu_gt),
        .alu_ovf  (alu_ovf)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural ALU ----------------
    typedef struct packed {
        logic         cout;
        logic         lt;
        logic         eq;
        logic         gt;
        logic         ovf;
        logic [W-1:0] z;
    } alu_res_t;

    // Flags with no meaning for an op are driven high so masking is visible.
    // The compare op yields "x <= y"; the scheduler removes the equal case.
    function automatic alu_res_t alu_fn(input logic [2:0] op, input logic [W-1:0] x,
                                        input logic [W-1:0] y, input logic cin);
        alu_res_t r;
        logic [W:0] wide;
        r      = '0;
        wide   = '0;
        r.lt   = (x < y);
        r.eq   = (x == y);
        r.gt   = (x > y);
        r.cout = 1'b1;
        r.ovf  = 1'b1;
        case (op)
            OP_AND: r.z = x & y;
            OP_OR:  r.z = x | y;
            OP_ADDU, OP_ADDS: begin
                wide   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
                r.z    = wide[W-1:0];
                r.cout = wide[W];
                r.ovf  = (op == OP_ADDU) ? wide[W]
                                         : ((x[W-1] == y[W-1]) && (r.z[W-1] != x[W-1]));
            end
            OP_SUBU, OP_SUBS: begin
                wide   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, cin};
                r.z    = wide[W-1:0];
                r.cout = wide[W];
                r.ovf  = (op == OP_SUBU) ? wide[W]
                                         : ((x[W-1] != y[W-1]) && (r.z[W-1] != x[W-1]));
            end
            OP_SLT:  r.z = {{(W-1){1'b0}}, (x <= y)};
            default: r.z = {W{1'b1}};
        endcase
        return r;
    endfunction

    alu_res_t alu_res;
    always_comb alu_res = alu_fn(alu_c, alu_x, alu_y, alu_cin);
    assign alu_z    = alu_res.z;
    assign alu_cout = alu_res.cout;
    assign alu_lt   = alu_res.lt;
    assign alu_eq   = alu_res.eq;
    assign alu_gt   = alu_res.gt;
    assign alu_ovf  = alu_res.ovf;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int           idx;
        logic [W-1:0] z;
        logic [4:0]   flags;
        logic         err;
    } rsp_t;

    rsp_t rsp_q[$];
    int   grant_q[$];

    int           ncyc   = 0;
    logic         m_busy = 1'b0;
    int           m_idx  = 0;
    int           m_last = NREQ - 1;
    int           m_vis  = 0;
    logic [2:0]   m_op;
    logic [W-1:0] m_x, m_y, m_z;
    logic         m_cin, m_err;
    logic [4:0]   m_flags;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Response a requester should see for an accepted operation.
    task automatic predict(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic cin);
        alu_res_t r;
        r       = alu_fn(op, x, y, cin);
        m_err   = (op == OP_RSVD);
        m_z     = '0;
        m_flags = '0;
        if (!m_err) begin
            m_z                = (op == OP_SLT && r.eq) ? '0 : r.z;
            m_flags[FLAG_COUT] = (op == OP_ADDU) ? r.cout : 1'b0;
            m_flags[FLAG_LT]   = r.lt;
            m_flags[FLAG_EQ]   = r.eq;
            m_flags[FLAG_GT]   = r.gt;
            m_flags[FLAG_OVF]  = (op == OP_ADDU || op == OP_ADDS || op == OP_SUBS) ? r.ovf : 1'b0;
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        logic [NREQ-1:0] exp_ready, exp_rvalid, rdy;
        int   g, obs_g;
        rsp_t e;
        g          = -1;
        obs_g      = -1;
        exp_ready  = '0;
        exp_rvalid = '0;
        @(negedge clk);
        if (!m_busy) begin
            g = rr_pick(bus.req_valid, m_last);
            if (g >= 0) exp_ready[g] = 1'b1;
        end else if (ncyc >= m_vis) begin
            exp_rvalid[m_idx] = 1'b1;
        end
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rvalid));
        check("busy", 32'(busy), 32'(m_busy));
        if (m_busy) begin
            check("alu_c", 32'(alu_c), 32'(m_op));
            check("alu_x", 32'(alu_x), 32'(m_x));
            check("alu_y", 32'(alu_y), 32'(m_y));
            check("alu_cin", 32'(alu_cin), 32'(m_cin));
        end
        if (exp_rvalid != '0) begin
            check("rsp_z", 32'(bus.rsp_z), 32'(m_z));
            check("rsp_flags", 32'(bus.rsp_flags), 32'(m_flags));
            check("rsp_err", 32'(bus.rsp_err), 32'(m_err));
        end
        rdy = bus.req_ready;
        for (int i = 0; i < NREQ; i++) if (rdy[i] && obs_g < 0) obs_g = i;
        e.idx   = m_idx;
        e.z     = bus.rsp_z;
        e.flags = bus.rsp_flags;
        e.err   = bus.rsp_err;
        @(posedge clk);
        ncyc++;
        if (!m_busy && g >= 0) begin
            m_busy = 1'b1;
            m_idx  = g;
            m_last = g;
            m_op   = bus.req_op[3*g +: 3];
            m_x    = bus.req_x[W*g +: W];
            m_y    = bus.req_y[W*g +: W];
            m_cin  = bus.req_cin[g];
            predict(m_op, m_x, m_y, m_cin);
            m_vis  = ncyc + ((m_op == OP_RSVD) ? 0 : ALU_LAT);
            grant_q.push_back(obs_g);
        end else if (m_busy && exp_rvalid != '0 && bus.rsp_ready[m_idx]) begin
            m_busy = 1'b0;
            rsp_q.push_back(e);
        end
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic cin);
        bus.req_valid[i]     = 1'b1;
        bus.req_op[3*i +: 3] = op;
        bus.req_x[W*i +: W]  = x;
        bus.req_y[W*i +: W]  = y;
        bus.req_cin[i]       = cin;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_alu_c"}, 32'(alu_c), 32'h0);
        check({tag, "_alu_x"}, 32'(alu_x), 32'h0);
        check({tag, "_alu_y"}, 32'(alu_y), 32'h0);
        check({tag, "_alu_cin"}, 32'(alu_cin), 32'h0);
        check({tag, "_rsp_z"}, 32'(bus.rsp_z), 32'h0);
        check({tag, "_rsp_flags"}, 32'(bus.rsp_flags), 32'h0);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'h0);
    endtask

    // Asynchronous assert away from the clock edge, release after two edges.
    task automatic do_reset(input string tag);
        bus.req_valid = '0;
        rst_n         = 1'b0;
        m_busy        = 1'b0;
        m_last        = NREQ - 1;
        #1;
        check_outputs_zero(tag);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Hold the driven requests until nops new grants, then drain to idle.
    task automatic run_ops(input string tag, input int nops, input int budget);
        int start;
        int n;
        start = grant_q.size();
        n     = 0;
        while ((grant_q.size() - start) < nops && n < budget) begin
            step();
            n++;
        end
        bus.req_valid = '0;
        while (m_busy && n < budget) begin
            step();
            n++;
        end
        check({tag, "_in_budget"}, 32'(n < budget), 32'h1);
    endtask

    int   n;
    int   nr;
    rsp_t r;

    initial begin
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_cin   = '0;
        bus.rsp_ready = '1;
        #1;
        do_reset("reset");

        // 1: unsigned add with carry out and wrap to zero.
        set_req(0, OP_ADDU, 16'hFFFF, 16'h0001, 1'b0);
        run_ops("t1", 1, 30);
        check("t1_nrsp", 32'(rsp_q.size()), 32'd1);
        r = rsp_q[rsp_q.size()-1];
        check("t1_idx", 32'(r.idx), 32'd0);
        check("t1_z", 32'(r.z), 32'h0);
        check("t1_cout", 32'(r.flags[FLAG_COUT]), 32'h1);
        check("t1_ovf", 32'(r.flags[FLAG_OVF]), 32'h1);
        check("t1_err", 32'(r.err), 32'h0);

        // 2: two requesters competing continuously from reset.
        do_reset("t2_reset");
        set_req(0, OP_AND, 16'(($urandom)), 16'(($urandom)), 1'b0);
        set_req(1, OP_OR, 16'(($urandom)), 16'(($urandom)), 1'b1);
        n = grant_q.size();
        run_ops("t2", 4, 80);
        check("t2_g0", 32'(grant_q[n]), 32'd0);
        check("t2_g1", 32'(grant_q[n+1]), 32'd1);
        check("t2_g2", 32'(grant_q[n+2]), 32'd0);
        check("t2_g3", 32'(grant_q[n+3]), 32'd1);

        // 3: reserved op answers with an error and skips the ALU wait.
        set_req(1, OP_RSVD, 16'h1234, 16'h1234, 1'b1);
        run_ops("t3", 1, 30);
        r = rsp_q[rsp_q.size()-1];
        check("t3_idx", 32'(r.idx), 32'd1);
        check("t3_err", 32'(r.err), 32'h1);
        check("t3_z", 32'(r.z), 32'h0);
        check("t3_flags", 32'(r.flags), 32'h0);

        // 4: set-less-than, equal and less cases.
        set_req(2, OP_SLT, 16'h0005, 16'h0005, 1'b0);
        run_ops("t4a", 1, 30);
        r = rsp_q[rsp_q.size()-1];
        check("t4a_z", 32'(r.z), 32'h0);
        check("t4a_eq", 32'(r.flags[FLAG_EQ]), 32'h1);
        set_req(2, OP_SLT, 16'h0003, 16'h0009, 1'b0);
        run_ops("t4b", 1, 30);
        r = rsp_q[rsp_q.size()-1];
        check("t4b_z", 32'(r.z), 32'h1);
        check("t4b_lt", 32'(r.flags[FLAG_LT]), 32'h1);

        // 5: response back-pressure with another requester waiting.
        bus.rsp_ready = '0;
        set_req(0, OP_SUBU, 16'h0010, 16'h0020, 1'b1);
        set_req(1, OP_ADDS, 16'h7FFF, 16'h0001, 1'b0);
        n = 0;
        while (!(m_busy && ncyc >= m_vis) && n < 30) begin
            step();
            if (m_busy) bus.req_valid[0] = 1'b0;
            n++;
        end
        check("t5_reach_resp", 32'(n < 30), 32'h1);
        nr = rsp_q.size();
        repeat (5) step();
        check("t5_no_handshake", 32'(rsp_q.size()), 32'(nr));
        check("t5_busy", 32'(busy), 32'h1);
        bus.rsp_ready = '1;
        run_ops("t5", 1, 40);
        check("t5_nrsp", 32'(rsp_q.size()), 32'(nr + 2));

        // 6: reset during execution drops the transaction.
        set_req(0, OP_ADDS, 16'h4000, 16'h4000, 1'b0);
        n = 0;
        while (!m_busy && n < 10) begin
            step();
            n++;
        end
        check("t6_accepted", 32'(m_busy), 32'h1);
        step();
        do_reset("t6_mid");
        nr = rsp_q.size();
        repeat (ALU_LAT + 3) step();
        check("t6_no_rsp", 32'(rsp_q.size()), 32'(nr));
        set_req(1, OP_SUBS, 16'h8000, 16'h0001, 1'b0);
        run_ops("t6", 1, 30);
        r = rsp_q[rsp_q.size()-1];
        check("t6_idx", 32'(r.idx), 32'd1);

        // Randomised traffic with random back-pressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                logic [W-1:0] x;
                x = 16'($urandom);
                bus.req_valid[i]     = ($urandom_range(0, 2) != 0);
                bus.req_op[3*i +: 3] = 3'($urandom_range(0, 7));
                bus.req_x[W*i +: W]  = x;
                bus.req_y[W*i +: W]  = ($urandom_range(0, 3) == 0) ? x : 16'($urandom);
                bus.req_cin[i]       = 1'($urandom);
                bus.rsp_ready[i]     = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        n = 0;
        while (m_busy && n < 40) begin
            step();
            n++;
        end
        check("rand_drained", 32'(m_busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
